// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC select, imem request, instruction split, valP/predicted-PC. Optional iaddq via FETCH_IADDQ_EN.
// Zero-cycle latency from imem ack to f_* bus; stall discards the fetched bytes and holds PC.
module fetch_stage #(
    parameter logic [63:0] PC_RESET = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic [3:0]  M_icode_i,
    input  logic        M_Cnd_i,
    input  logic [63:0] M_valA_i,
    input  logic [3:0]  W_icode_i,
    input  logic [63:0] W_valM_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [79:0] imem_data_i,
    input  logic        imem_err_i,
    output logic [3:0]  f_icode_o,
    output logic [3:0]  f_ifun_o,
    output logic [3:0]  f_rA_o,
    output logic [3:0]  f_rB_o,
    output logic [63:0] f_valC_o,
    output logic [63:0] f_valP_o,
    output logic [3:0]  f_stat_o
);

    localparam logic [3:0] STAT_BUB = 4'd0;
    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_HLT = 4'd2;
    localparam logic [3:0] STAT_ADR = 4'd3;
    localparam logic [3:0] STAT_INS = 4'd4;

    localparam logic [3:0] I_NOP  = 4'h1;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;
    localparam logic [3:0] R_NONE = 4'hF;

    typedef enum logic {RUN = 1'b0, STOP = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [63:0] pred_pc_q;

    logic        mispredict, ret_seen, redirect;
    logic [63:0] f_pc;
    logic        accept;
    logic [3:0]  raw_icode, raw_ifun;
    logic        need_regids, need_valc, instr_valid;
    logic [63:0] dec_valc, dec_valp;

    assign mispredict  = (M_icode_i == I_JXX) && !M_Cnd_i;
    assign ret_seen    = (W_icode_i == I_RET);
    assign redirect    = mispredict || ret_seen;
    assign f_pc        = mispredict ? M_valA_i : (ret_seen ? W_valM_i : pred_pc_q);
    assign imem_addr_o = f_pc;
    assign accept      = imem_req_o && imem_ack_i && !stall_i;

    assign raw_icode = imem_data_i[7:4];
    assign raw_ifun  = imem_data_i[3:0];

    always_comb begin
        need_regids = 1'b0;
        need_valc   = 1'b0;
        instr_valid = 1'b0;
        case (raw_icode)
            4'h0, 4'h1, 4'h9: instr_valid = (raw_ifun == 4'd0);
            4'h2:             begin need_regids = 1'b1; instr_valid = (raw_ifun <= 4'd6); end
            4'h3, 4'h4, 4'h5: begin need_regids = 1'b1; need_valc = 1'b1; instr_valid = (raw_ifun == 4'd0); end
            4'h6:             begin need_regids = 1'b1; instr_valid = (raw_ifun <= 4'd3); end
            4'h7:             begin need_valc = 1'b1; instr_valid = (raw_ifun <= 4'd6); end
            4'h8:             begin need_valc = 1'b1; instr_valid = (raw_ifun == 4'd0); end
            4'hA, 4'hB:       begin need_regids = 1'b1; instr_valid = (raw_ifun == 4'd0); end
`ifdef FETCH_IADDQ_EN
            4'hC:             begin need_regids = 1'b1; need_valc = 1'b1; instr_valid = (raw_ifun == 4'd0); end
`else
            4'hC:             instr_valid = 1'b0;
`endif
            default:          instr_valid = 1'b0;
        endcase
    end

    // Immediate sits after the register byte when one is present.
    assign dec_valc = !need_valc  ? 64'd0 :
                      need_regids ? imem_data_i[79:16] : imem_data_i[71:8];
    assign dec_valp = f_pc + 64'd1 + {63'd0, need_regids} + (need_valc ? 64'd8 : 64'd0);

    always_comb begin
        f_icode_o = I_NOP;
        f_ifun_o  = 4'd0;
        f_rA_o    = R_NONE;
        f_rB_o    = R_NONE;
        f_valC_o  = 64'd0;
        f_valP_o  = 64'd0;
        f_stat_o  = STAT_BUB;
        if (accept) begin
            if (imem_err_i) begin
                f_stat_o = STAT_ADR;
            end else begin
                f_icode_o = raw_icode;
                f_ifun_o  = raw_ifun;
                f_rA_o    = need_regids ? imem_data_i[15:12] : R_NONE;
                f_rB_o    = need_regids ? imem_data_i[11:8]  : R_NONE;
                f_valC_o  = dec_valc;
                f_valP_o  = dec_valp;
                if (!instr_valid)
                    f_stat_o = STAT_INS;
                else if (raw_icode == 4'h0)
                    f_stat_o = STAT_HLT;
                else
                    f_stat_o = STAT_AOK;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && (f_stat_o != STAT_AOK)) state_d = STOP;
            STOP:    if (redirect) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        imem_req_o = (state_q == RUN) && !rst_i;
    end

    // A redirect that arrives without an accepted fetch is parked here so it is never lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            pred_pc_q <= PC_RESET;
        else if (accept)
            pred_pc_q <= ((f_icode_o == I_JXX) || (f_icode_o == I_CALL)) ? f_valC_o : f_valP_o;
        else if (redirect)
            pred_pc_q <= f_pc;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized traffic against a length-table fetch model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic [3:0]  M_icode, W_icode;
    logic        M_Cnd;
    logic [63:0] M_valA, W_valM;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack, imem_err;
    logic [79:0] imem_data;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB, f_stat;
    logic [63:0] f_valC, f_valP;

    fetch_stage #(.PC_RESET(64'h0)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .M_icode_i(M_icode), .M_Cnd_i(M_Cnd), .M_valA_i(M_valA),
        .W_icode_i(W_icode), .W_valM_i(W_valM),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_ack_i(imem_ack), .imem_data_i(imem_data), .imem_err_i(imem_err),
        .f_icode_o(f_icode), .f_ifun_o(f_ifun), .f_rA_o(f_rA), .f_rB_o(f_rB),
        .f_valC_o(f_valC), .f_valP_o(f_valP), .f_stat_o(f_stat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode, ifun, rA, rB, stat;
        logic [63:0] valC, valP;
    } fexp_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem [256];
    logic        m_run;
    logic [63:0] m_pc;
    logic        l_req;
    logic [63:0] l_addr, l_valC, l_valP;
    logic [3:0]  l_icode, l_rA, l_rB, l_stat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic fexp_t bubble();
        fexp_t e;
        e.icode = 4'h1; e.ifun = 4'h0; e.rA = 4'hF; e.rB = 4'hF;
        e.valC = 64'd0; e.valP = 64'd0; e.stat = 4'd0;
        return e;
    endfunction

    // Instruction length drives everything else: register byte present for lengths 2 and 10,
    // immediate occupies the last eight bytes for lengths 9 and 10.
    function automatic fexp_t model_fetch(input logic [63:0] pc, input logic [79:0] data);
        fexp_t      e;
        logic [7:0] b [10];
        int         len;
        logic       ok;
        for (int i = 0; i < 10; i++) b[i] = data[8*i +: 8];
        e.icode = b[0][7:4];
        e.ifun  = b[0][3:0];
        case (e.icode)
            4'h2, 4'h6, 4'hA, 4'hB: len = 2;
            4'h3, 4'h4, 4'h5:       len = 10;
            4'h7, 4'h8:             len = 9;
`ifdef FETCH_IADDQ_EN
            4'hC:                   len = 10;
`endif
            default:                len = 1;
        endcase
        case (e.icode)
            4'h2, 4'h7: ok = (e.ifun <= 6);
            4'h6:       ok = (e.ifun <= 3);
`ifdef FETCH_IADDQ_EN
            4'hC:       ok = (e.ifun == 0);
`endif
            default:    ok = (e.icode <= 4'hB) && (e.ifun == 0);
        endcase
        e.rA = (len == 2 || len == 10) ? b[1][7:4] : 4'hF;
        e.rB = (len == 2 || len == 10) ? b[1][3:0] : 4'hF;
        e.valC = 64'd0;
        if (len >= 9)
            for (int i = 0; i < 8; i++) e.valC[8*i +: 8] = b[len - 8 + i];
        e.valP = pc + 64'(len);
        e.stat = !ok ? 4'd4 : (e.icode == 4'h0) ? 4'd2 : 4'd1;
        return e;
    endfunction

    // One clock: inputs already driven just after the rising edge; compare at the falling edge.
    task automatic cycle();
        fexp_t       e;
        logic        mis, ret, acc;
        logic [63:0] fpc;
        logic [79:0] d;
        logic [7:0]  a;
        if (rst) begin m_run = 1'b1; m_pc = 64'h0; end
        mis = (M_icode == 4'h7) && !M_Cnd;
        ret = (W_icode == 4'h9);
        fpc = mis ? M_valA : ret ? W_valM : m_pc;
        for (int i = 0; i < 10; i++) begin
            a = fpc[7:0] + 8'(i);
            d[8*i +: 8] = mem[a];
        end
        imem_data = d;
        acc = m_run && !rst && imem_ack && !stall;
        e = bubble();
        if (acc) begin
            if (imem_err) e.stat = 4'd3;
            else e = model_fetch(fpc, d);
        end
        @(negedge clk);
        chk("req",   {63'd0, imem_req}, {63'd0, m_run && !rst});
        chk("addr",  imem_addr, fpc);
        chk("icode", {60'd0, f_icode}, {60'd0, e.icode});
        chk("ifun",  {60'd0, f_ifun},  {60'd0, e.ifun});
        chk("rA",    {60'd0, f_rA},    {60'd0, e.rA});
        chk("rB",    {60'd0, f_rB},    {60'd0, e.rB});
        chk("valC",  f_valC, e.valC);
        chk("valP",  f_valP, e.valP);
        chk("stat",  {60'd0, f_stat},  {60'd0, e.stat});
        l_req = imem_req; l_addr = imem_addr; l_icode = f_icode; l_rA = f_rA; l_rB = f_rB;
        l_valC = f_valC; l_valP = f_valP; l_stat = f_stat;
        @(posedge clk);
        if (!rst) begin
            if (acc) begin
                m_pc = (e.icode == 4'h7 || e.icode == 4'h8) ? e.valC : e.valP;
                if (e.stat != 4'd1) m_run = 1'b0;
            end else if (mis || ret) begin
                m_pc  = fpc;
                m_run = 1'b1;
            end
        end
        #1;
    endtask

    task automatic no_redirect();
        M_icode = 4'h1; M_Cnd = 1'b1; M_valA = 64'd0;
        W_icode = 4'h1; W_valM = 64'd0;
    endtask

    task automatic put(input logic [7:0] addr, input logic [79:0] bytes);
        logic [7:0] a;
        for (int i = 0; i < 10; i++) begin
            a = addr + 8'(i);
            mem[a] = bytes[8*i +: 8];
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h10;
        rst = 1'b1; stall = 1'b0; imem_ack = 1'b0; imem_err = 1'b0; imem_data = '0;
        no_redirect();
        m_run = 1'b1; m_pc = 64'h0;
        #2;

        // Reset: no request, bubble out
        cycle();
        cycle();
        chk("rst_req", {63'd0, l_req}, 64'd0);
        chk("rst_stat", {60'd0, l_stat}, 64'd0);
        rst = 1'b0;

        // irmovq $0xA, %rdx at 0
        put(8'h00, 80'h0000_0000_0000_000A_F230);
        imem_ack = 1'b1;
        cycle();
        chk("t1_icode", {60'd0, l_icode}, 64'd3);
        chk("t1_rA", {60'd0, l_rA}, 64'hF);
        chk("t1_rB", {60'd0, l_rB}, 64'h2);
        chk("t1_valC", l_valC, 64'hA);
        chk("t1_valP", l_valP, 64'hA);
        chk("t1_next", imem_addr, 64'hA);

        // jmp 0x100 at 0x20, reached by a mispredict redirect captured without ack
        put(8'h20, 80'h00_0000_0000_0000_0100_70);
        imem_ack = 1'b0;
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h20;
        cycle();
        no_redirect();
        imem_ack = 1'b1;
        cycle();
        chk("t2_addr", l_addr, 64'h20);
        chk("t2_valC", l_valC, 64'h100);
        chk("t2_valP", l_valP, 64'h29);
        chk("t2_next", imem_addr, 64'h100);

        // Stall with ack: bubbles, address held, then delivered once (0x100 aliases the irmovq)
        stall = 1'b1;
        repeat (3) begin
            cycle();
            chk("t3_stall_stat", {60'd0, l_stat}, 64'd0);
            chk("t3_stall_addr", l_addr, 64'h100);
        end
        stall = 1'b0;
        cycle();
        chk("t3_icode", {60'd0, l_icode}, 64'd3);
        chk("t3_next", imem_addr, 64'h10A);

        // halt stops fetch; mispredict resumes at 0x40
        put(8'h50, 80'h0);
        W_icode = 4'h9; W_valM = 64'h50; imem_ack = 1'b0;
        cycle();
        no_redirect(); imem_ack = 1'b1;
        cycle();
        chk("t4_stat", {60'd0, l_stat}, 64'd2);
        cycle();
        chk("t4_req_off", {63'd0, l_req}, 64'd0);
        chk("t4_bubble", {60'd0, l_stat}, 64'd0);
        M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h40;
        cycle();
        no_redirect();
        chk("t4_resume_addr", imem_addr, 64'h40);
        chk("t4_resume_req", {63'd0, imem_req}, 64'd1);

        // address error -> ADR/STOP; ret resumes at 0x80
        imem_err = 1'b1;
        cycle();
        imem_err = 1'b0;
        chk("t5_stat", {60'd0, l_stat}, 64'd3);
        chk("t5_icode", {60'd0, l_icode}, 64'd1);
        cycle();
        chk("t5_req_off", {63'd0, l_req}, 64'd0);
        W_icode = 4'h9; W_valM = 64'h80;
        cycle();
        no_redirect();
        chk("t5_resume_addr", imem_addr, 64'h80);

        // iaddq
        put(8'h80, 80'h0000_0000_0000_0005_F3C0);
        cycle();
`ifdef FETCH_IADDQ_EN
        chk("t6_stat", {60'd0, l_stat}, 64'd1);
        chk("t6_valP", l_valP, 64'h8A);
        chk("t6_req", {63'd0, imem_req}, 64'd1);
`else
        chk("t6_stat", {60'd0, l_stat}, 64'd4);
        chk("t6_req", {63'd0, imem_req}, 64'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) == 0) mem[$urandom_range(0, 255)] = 8'($urandom);
            stall    = ($urandom_range(0, 3) == 0);
            imem_ack = ($urandom_range(0, 4) != 0);
            imem_err = ($urandom_range(0, 19) == 0);
            M_icode  = ($urandom_range(0, 5) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
            M_Cnd    = 1'($urandom);
            M_valA   = {32'($urandom), 32'($urandom)};
            W_icode  = ($urandom_range(0, 7) == 0) ? 4'h9 : 4'h1;
            W_valM   = {32'($urandom), 32'($urandom)};
            rst      = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
